// File: rtl/sound_arbiter_pkg.sv
// Shared constants for the piano sound path: note table, octave codes,
// arbiter state encoding and helpers for pitch and LED decoding.
package sound_arbiter_pkg;

    localparam int unsigned NOTE_KEY_BITS = 7;

    localparam logic [1:0] OCT_LOW  = 2'd0;
    localparam logic [1:0] OCT_MID  = 2'd1;
    localparam logic [1:0] OCT_HIGH = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_PLAY = 2'd1,
        ARB_GAP  = 2'd2
    } arb_state_t;

    function automatic int unsigned note_freq(input int unsigned note);
        case (note)
            1:       return 262;
            2:       return 294;
            3:       return 330;
            4:       return 349;
            5:       return 392;
            6:       return 440;
            7:       return 494;
            default: return 0;
        endcase
    endfunction

    // Mid-octave half period in clock cycles, never below 1.
    function automatic int unsigned base_half(input int unsigned clk_hz, input int unsigned note);
        int unsigned f;
        int unsigned h;
        f = note_freq(note);
        if (f == 0) return 1;
        h = clk_hz / (2 * f);
        return (h == 0) ? 1 : h;
    endfunction

    function automatic logic [NOTE_KEY_BITS-1:0] note_led(input logic [2:0] note);
        note_led = '0;
        if (note != 3'd0) note_led[note - 3'd1] = 1'b1;
    endfunction

endpackage

// File: rtl/sound_arbiter_tone_gen.sv
// Square-wave tone generator: period lookup, octave scaling and toggle counter.
module tone_gen
    import sound_arbiter_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] note,
    input  logic [1:0] oct,
    output logic       buzzer
);

    localparam int unsigned MAX_HALF = 2 * base_half(CLK_HZ, 1);
    localparam int unsigned CNT_W    = $clog2(MAX_HALF + 1);
    localparam int unsigned BASE [8] = '{1,
                                         base_half(CLK_HZ, 1), base_half(CLK_HZ, 2),
                                         base_half(CLK_HZ, 3), base_half(CLK_HZ, 4),
                                         base_half(CLK_HZ, 5), base_half(CLK_HZ, 6),
                                         base_half(CLK_HZ, 7)};

    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        case (oct)
            OCT_LOW:  half = CNT_W'(BASE[note] * 2);
            OCT_HIGH: half = (BASE[note] > 1) ? CNT_W'(BASE[note] / 2) : CNT_W'(1);
            default:  half = CNT_W'(BASE[note]);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            buzzer <= 1'b0;
        end else if (!en || note == 3'd0) begin
            cnt    <= '0;
            buzzer <= 1'b0;
        end else if (cnt >= half - CNT_W'(1)) begin
            cnt    <= '0;
            buzzer <= ~buzzer;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sound_arbiter.sv
// Fixed-priority arbiter for the single buzzer: grants one timed note at a
// time, times it in ms/unit steps, then holds a silent gap before re-arbitrating.
module sound_arbiter
    import sound_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned CLK_HZ  = 100000000,
    parameter int unsigned UNIT_MS = 125,
    parameter int unsigned GAP_MS  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [3*N_REQ-1:0]   req_note,
    input  logic [2*N_REQ-1:0]   req_oct,
    input  logic [3*N_REQ-1:0]   req_len,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     ack,
    output logic                 busy,
    output logic [6:0]           cur_led,
    output logic                 buzzer
);

    localparam int unsigned MS_CYC  = CLK_HZ / 1000;
    localparam int unsigned GAP_CYC = GAP_MS * MS_CYC;
    localparam int unsigned PRE_W   = (MS_CYC  > 1) ? $clog2(MS_CYC)  : 1;
    localparam int unsigned MSC_W   = (UNIT_MS > 1) ? $clog2(UNIT_MS) : 1;
    localparam int unsigned GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int unsigned IDX_W   = (N_REQ   > 1) ? $clog2(N_REQ)   : 1;

    arb_state_t       state;
    logic [PRE_W-1:0] pre;
    logic [MSC_W-1:0] ms_cnt;
    logic [2:0]       unit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [IDX_W-1:0] gidx;
    logic [2:0]       note_q;
    logic [1:0]       oct_q;
    logic [2:0]       len_q;

    logic [IDX_W-1:0] sel_idx;
    logic [2:0]       sel_note;
    logic [1:0]       sel_oct;
    logic [2:0]       sel_len;
    logic             ms_tick;
    logic             last_unit;
    logic             tone_buz;

    always_comb begin
        sel_idx = '0;
        for (int unsigned i = N_REQ; i > 0; i--) begin
            if (req[i-1]) sel_idx = IDX_W'(i - 1);
        end
        sel_note = req_note[3*int'(sel_idx) +: 3];
        sel_oct  = req_oct[2*int'(sel_idx) +: 2];
        sel_len  = req_len[3*int'(sel_idx) +: 3];
    end

    assign ms_tick   = (pre == PRE_W'(MS_CYC - 1));
    assign last_unit = ms_tick && (ms_cnt == MSC_W'(UNIT_MS - 1)) && (unit_cnt == len_q - 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            grant    <= '0;
            ack      <= '0;
            busy     <= 1'b0;
            cur_led  <= '0;
            pre      <= '0;
            ms_cnt   <= '0;
            unit_cnt <= '0;
            gap_cnt  <= '0;
            gidx     <= '0;
            note_q   <= '0;
            oct_q    <= '0;
            len_q    <= '0;
        end else begin
            ack <= '0;
            case (state)
                ARB_IDLE: begin
                    if (|req) begin
                        gidx     <= sel_idx;
                        note_q   <= sel_note;
                        oct_q    <= sel_oct;
                        len_q    <= (sel_len == 3'd0) ? 3'd1 : sel_len;
                        grant    <= N_REQ'(1) << sel_idx;
                        cur_led  <= note_led(sel_note);
                        busy     <= 1'b1;
                        pre      <= '0;
                        ms_cnt   <= '0;
                        unit_cnt <= '0;
                        state    <= ARB_PLAY;
                    end
                end
                ARB_PLAY: begin
                    // Completion is checked before withdrawal so a same-cycle drop still acks.
                    if (last_unit || !req[gidx]) begin
                        ack     <= last_unit ? grant : '0;
                        grant   <= '0;
                        cur_led <= '0;
                        gap_cnt <= '0;
                        state   <= ARB_GAP;
                    end else if (ms_tick) begin
                        pre <= '0;
                        if (ms_cnt == MSC_W'(UNIT_MS - 1)) begin
                            ms_cnt   <= '0;
                            unit_cnt <= unit_cnt + 3'd1;
                        end else begin
                            ms_cnt <= ms_cnt + MSC_W'(1);
                        end
                    end else begin
                        pre <= pre + PRE_W'(1);
                    end
                end
                ARB_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                        busy  <= 1'b0;
                        state <= ARB_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    tone_gen #(.CLK_HZ(CLK_HZ)) u_tone (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state == ARB_PLAY),
        .note   (note_q),
        .oct    (oct_q),
        .buzzer (tone_buz)
    );

    // Masking by state silences the pin on the abort edge itself.
    assign buzzer = tone_buz & (state == ARB_PLAY);

endmodule

// File: tb/tb_sound_arbiter.sv
// Directed bench for sound_arbiter with a note-level reference model.
module tb_sound_arbiter;

    localparam int CLK_HZ   = 8000;
    localparam int MS_CYC   = CLK_HZ / 1000;
    localparam int UNIT_CYC = 2 * MS_CYC;
    localparam int GAP_CYC  = 1 * MS_CYC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [11:0] req_note = '0;
    logic [7:0]  req_oct = '0;
    logic [11:0] req_len = '0;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        busy;
    logic [6:0]  cur_led;
    logic        buzzer;

    int n_vec = 0;
    int n_err = 0;

    sound_arbiter #(.N_REQ(4), .CLK_HZ(CLK_HZ), .UNIT_MS(2), .GAP_MS(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_note(req_note), .req_oct(req_oct),
        .req_len(req_len), .grant(grant), .ack(ack), .busy(busy), .cur_led(cur_led),
        .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int tone_half(input int note, input int oct);
        int f [8] = '{0, 262, 294, 330, 349, 392, 440, 494};
        int h;
        if (note == 0) return 0;
        h = CLK_HZ / (2 * f[note]);
        if (oct == 0) h = h * 2;
        else if (oct == 2) h = (h / 2 < 1) ? 1 : h / 2;
        return h;
    endfunction

    // Note-level model: who owns the buzzer, how long into the note, gap remaining.
    int         m_owner = -1;
    int         m_t = 0;
    int         m_dur = 0;
    int         m_half = 0;
    int         m_gap = 0;
    int         m_ack = -1;
    logic [6:0] m_led = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_t = 0; m_gap = 0; m_ack = -1; m_half = 0; m_led = '0;
        end else begin
            m_ack = -1;
            if (m_owner >= 0) begin
                if (m_t + 1 == m_dur) begin
                    m_ack = m_owner; m_owner = -1; m_gap = GAP_CYC;
                end else if (!req[m_owner]) begin
                    m_owner = -1; m_gap = GAP_CYC;
                end else begin
                    m_t++;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (req != 4'b0) begin
                int nt, oc, ln;
                for (int i = 3; i >= 0; i--) if (req[i]) m_owner = i;
                nt = int'(req_note[m_owner*3 +: 3]);
                oc = int'(req_oct[m_owner*2 +: 2]);
                ln = int'(req_len[m_owner*3 +: 3]);
                m_t    = 0;
                m_dur  = ((ln == 0) ? 1 : ln) * UNIT_CYC;
                m_half = tone_half(nt, oc);
                m_led  = (nt == 0) ? 7'd0 : (7'd1 << (nt - 1));
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] eg, ea;
        logic       eb, ez;
        logic [6:0] el;
        eg = (m_owner >= 0) ? (4'd1 << m_owner) : 4'd0;
        ea = (m_ack >= 0) ? (4'd1 << m_ack) : 4'd0;
        eb = (m_owner >= 0) || (m_gap > 0);
        el = (m_owner >= 0) ? m_led : 7'd0;
        ez = (m_owner >= 0 && m_half > 0) ? 1'((m_t / m_half) % 2) : 1'b0;
        check("cycle", {grant, ack, busy, cur_led, buzzer}, {eg, ea, eb, el, ez});
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input int note, input int oct, input int len);
        req_note[i*3 +: 3] = 3'(note);
        req_oct[i*2 +: 2]  = 2'(oct);
        req_len[i*3 +: 3]  = 3'(len);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            step(1);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        step(2);
        check("reset_outs", {grant, ack, busy, cur_led, buzzer}, 32'd0);
        rst_n = 1'b1;
        step(1);

        // Single note: mid la, 3 units
        set_slot(2, 6, 1, 3);
        req = 4'b0100;
        step(1);
        check("single_grant", 32'(grant), 32'h4);
        check("single_led", 32'(cur_led), 32'h20);
        step(8);
        check("single_buz8", 32'(buzzer), 32'd0);
        step(1);
        check("single_buz9", 32'(buzzer), 32'd1);
        step(38);
        check("single_noack47", 32'(ack), 32'd0);
        step(1);
        check("single_ack48", 32'(ack), 32'h4);
        req = 4'b0000;
        step(7);
        check("single_gap_busy", 32'(busy), 32'd1);
        step(1);
        check("single_idle", 32'(busy), 32'd0);
        step(1);

        // Priority: 1 and 3 together, index 1 wins
        set_slot(1, 3, 1, 1);
        set_slot(3, 5, 1, 1);
        req = 4'b1010;
        step(1);
        check("prio_grant1", 32'(grant), 32'h2);
        step(16);
        check("prio_ack1", 32'(ack), 32'h2);
        req = 4'b1000;
        step(8);
        check("prio_no_overlap", 32'(grant), 32'd0);
        step(1);
        check("prio_grant3", 32'(grant), 32'h8);
        step(16);
        check("prio_ack3", 32'(ack), 32'h8);
        req = 4'b0000;
        wait_idle();

        // Abort during a high note while the buzzer is high
        set_slot(0, 6, 2, 7);
        req = 4'b0001;
        step(1);
        check("abort_grant", 32'(grant), 32'h1);
        step(5);
        check("abort_buz_pre", 32'(buzzer), 32'd1);
        req = 4'b0000;
        step(1);
        check("abort_outs", {grant, ack, buzzer}, 32'd0);
        check("abort_busy", 32'(busy), 32'd1);
        step(7);
        check("abort_gap_end", 32'(busy), 32'd1);
        step(1);
        check("abort_idle", 32'(busy), 32'd0);

        // Low octave do: toggle after 30 cycles
        set_slot(1, 1, 0, 7);
        req = 4'b0010;
        step(30);
        check("low_buz29", 32'(buzzer), 32'd0);
        step(1);
        check("low_buz30", 32'(buzzer), 32'd1);
        req = 4'b0000;
        wait_idle();

        // High octave do: toggle every 7 cycles
        set_slot(1, 1, 2, 1);
        req = 4'b0010;
        step(7);
        check("high_buz6", 32'(buzzer), 32'd0);
        step(1);
        check("high_buz7", 32'(buzzer), 32'd1);
        step(7);
        check("high_buz14", 32'(buzzer), 32'd0);
        step(2);
        check("high_ack16", 32'(ack), 32'h2);
        req = 4'b0000;
        wait_idle();

        // Rest: silent, timed normally
        set_slot(2, 0, 1, 2);
        req = 4'b0100;
        step(1);
        check("rest_led", 32'(cur_led), 32'd0);
        step(32);
        check("rest_ack32", 32'(ack), 32'h4);
        req = 4'b0000;
        wait_idle();

        // len=0 and oct=3 behave as one unit, mid octave
        set_slot(3, 6, 3, 0);
        req = 4'b1000;
        step(9);
        check("len0_buz8", 32'(buzzer), 32'd0);
        step(1);
        check("len0_buz9", 32'(buzzer), 32'd1);
        step(7);
        check("len0_ack16", 32'(ack), 32'h8);
        req = 4'b0000;
        wait_idle();

        // Reset mid-PLAY, request held through it
        set_slot(3, 6, 1, 2);
        req = 4'b1000;
        step(11);
        check("rst_buz_pre", 32'(buzzer), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_async", {grant, ack, busy, cur_led, buzzer}, 32'd0);
        step(2);
        rst_n = 1'b1;
        step(1);
        check("rst_regrant", 32'(grant), 32'h8);
        step(31);
        check("rst_noack31", 32'(ack), 32'd0);
        step(1);
        check("rst_ack32", 32'(ack), 32'h8);
        req = 4'b0000;
        wait_idle();
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
